tdm_demux_1to4: RTL and testbench
=================================

Name: tdm_demux_1to4

Overview:
- Receive end of the team's 4:1 time-division mux link: takes one serial slot stream plus a frame marker and rebuilds the four parallel channels.
- Each valid beat carries one WIDTH-bit slot; slot 0 is flagged by frame_sync.
- After slot 3 of a frame, all four channels update together on a registered output.
- Tracks frame alignment (HUNT/LOCKED), flags misaligned markers, and drops lock after repeated missing markers.

Parameters:
- WIDTH, 1: bits per slot (per channel).
- MISS_LIMIT, 3: consecutive slot-0 beats with no frame_sync before lock is dropped; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  slot data.
- din_valid  input  1  din/frame_sync qualify this cycle.
- frame_sync  input  1  this beat is slot 0; ignored when din_valid=0.
- data_out  output  4*WIDTH  frame channels; ch k at [k*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle pulse: data_out updated.
- locked  output  1  state is LOCKED.
- sync_err  output  1  one-cycle pulse: frame_sync seen at slot != 0 while LOCKED.

Behaviour:
- Reset (async assert, sync release): data_out=0, out_valid=0, locked=0, sync_err=0, slot=0, miss_cnt=0, shadow=0, state=HUNT.
- Only beats with din_valid=1 advance anything. Idle cycles hold all state. Pulses are low on idle cycles.
- HUNT:
  - Beats without frame_sync are discarded.
  - A beat with frame_sync: shadow[0]<=din, slot<=1, state<=LOCKED, miss_cnt<=0.
- LOCKED, normal beat:
  - shadow[slot]<=din; slot<=slot+1, wrapping 3->0.
  - At slot 3: data_out<={din, shadow[2], shadow[1], shadow[0]} and out_valid=1 in the next cycle.
  - Latency: the beat carrying slot 3 to out_valid high is 1 clk.
- LOCKED, frame_sync at slot != 0:
  - sync_err pulses.
  - The partial frame is discarded (no out_valid); this beat is taken as slot 0: shadow[0]<=din, slot<=1.
  - miss_cnt<=0. State stays LOCKED.
- LOCKED, slot 0 without frame_sync:
  - miss_cnt++ and the beat is still stored as slot 0.
  - If miss_cnt reaches MISS_LIMIT: state<=HUNT, slot<=0, miss_cnt<=0, partial frame discarded, locked falls the next cycle.
- LOCKED, slot 0 with frame_sync: miss_cnt<=0.
- Stale output: data_out holds its last frame through HUNT; it is never cleared except by reset.
- Simultaneous events:
  - A sync_err beat never produces out_valid in the same cycle.
  - A slot-3 beat completes the frame even if the next beat is misaligned.
- Reset mid-frame: partial shadow contents are lost; no out_valid is emitted.
- Outputs are all registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package tdm_pkg:
  - NUM_SLOTS=4 and SLOT_W=2.
  - typedef tdm_state_e {HUNT, LOCKED}.
  - Reused by the planned tdm_mux_4to1 transmitter (rotating select counter plus frame_sync generation).
- One natural sub-module, tdm_frame_tracker: state, slot counter, miss counter, sync_err. It emits slot index, store-enable and frame-complete.
- The top level holds the shadow and output registers.

Test Plan:
- Reset, then 1-bit frames with sync on slot 0, slot bits 1,0,1,1 -> locked=1 after the first sync beat; out_valid one cycle after the 4th beat; data_out=4'b1101.
- Same frame with din_valid=0 gaps of 2 cycles between beats -> identical data_out=4'b1101; exactly one out_valid pulse; nothing changes during gaps.
- While locked, assert frame_sync on slot 2 -> sync_err pulse; no out_valid for the partial frame; next 3 beats 0,1,0 complete a frame {0,1,0,din@sync}.
- Omit frame_sync for 3 consecutive slot-0 beats (MISS_LIMIT=3) -> locked drops after the 3rd; data_out keeps the last value; beats before the next sync are ignored.
- Beats without frame_sync after reset -> stays in HUNT, no out_valid. First sync then acquires lock.
- WIDTH=8: slots 0xA1,0xB2,0xC3,0xD4 -> data_out=0xD4C3B2A1. Assert rst_n low mid-frame -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 4-slot TDM link: slot count, slot index width and
// the frame-alignment state type. Used by the tdm_demux_1to4 receiver and
// intended for the tdm_mux_4to1 transmitter as well.
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    // Index of the slot that closes a frame.
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_frame_tracker.sv
// -----------------------------------------------------------------------------
// tdm_frame_tracker
// Frame alignment control for the TDM receiver: HUNT/LOCKED state, slot
// counter, consecutive-missing-marker counter and the sync error pulse.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_valid         beat qualifier; nothing advances when low
//   i_sync          frame marker of the current beat
//   o_wr_en         store the current beat into shadow slot o_wr_slot
//   o_wr_slot       shadow slot index for this beat
//   o_frame_done    this beat is slot 3 of a good frame (combinational)
//   o_locked        registered: state is LOCKED
//   o_sync_err      registered one-cycle pulse: marker seen at slot != 0
// -----------------------------------------------------------------------------
module tdm_frame_tracker
    import tdm_pkg::*;
#(
    parameter int MISS_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic              o_wr_en,
    output logic [SLOT_W-1:0] o_wr_slot,
    output logic              o_frame_done,
    output logic              o_locked,
    output logic              o_sync_err
);

    localparam logic [3:0] MISS_LIMIT_V = 4'(MISS_LIMIT);

    tdm_state_e        r_state, w_next_state;
    logic [SLOT_W-1:0] r_slot, w_next_slot;
    logic [3:0]        r_miss_cnt, w_next_miss_cnt;
    logic              r_sync_err, w_next_sync_err;
    logic [3:0]        w_miss_inc;

    // Miss count never exceeds MISS_LIMIT-1 (<= 14), so the increment cannot wrap.
    assign w_miss_inc = r_miss_cnt + 4'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_slot     <= '0;
            r_miss_cnt <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_slot     <= w_next_slot;
            r_miss_cnt <= w_next_miss_cnt;
            r_sync_err <= w_next_sync_err;
        end
    end

    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_slot     = r_slot;
        w_next_miss_cnt = r_miss_cnt;
        w_next_sync_err = 1'b0;
        o_wr_en         = 1'b0;
        o_wr_slot       = r_slot;
        o_frame_done    = 1'b0;

        if (i_valid) begin
            case (r_state)
                HUNT: begin
                    if (i_sync) begin
                        o_wr_en         = 1'b1;
                        o_wr_slot       = '0;
                        w_next_slot     = SLOT_W'(1);
                        w_next_miss_cnt = '0;
                        w_next_state    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (i_sync && (r_slot != '0)) begin
                        // Misaligned marker: drop the partial frame and restart at slot 0.
                        w_next_sync_err = 1'b1;
                        o_wr_en         = 1'b1;
                        o_wr_slot       = '0;
                        w_next_slot     = SLOT_W'(1);
                        w_next_miss_cnt = '0;
                    end else if (r_slot == '0) begin
                        if (i_sync) begin
                            w_next_miss_cnt = '0;
                            o_wr_en         = 1'b1;
                            w_next_slot     = SLOT_W'(1);
                        end else if (w_miss_inc == MISS_LIMIT_V) begin
                            w_next_state    = HUNT;
                            w_next_slot     = '0;
                            w_next_miss_cnt = '0;
                        end else begin
                            // Marker missing but frame timing is trusted until the limit.
                            w_next_miss_cnt = w_miss_inc;
                            o_wr_en         = 1'b1;
                            w_next_slot     = SLOT_W'(1);
                        end
                    end else begin
                        o_wr_en      = 1'b1;
                        o_frame_done = (r_slot == LAST_SLOT);
                        w_next_slot  = r_slot + SLOT_W'(1);  // 3 wraps to 0
                    end
                end
                default: begin
                    w_next_state = HUNT;
                end
            endcase
        end
    end

    assign o_locked   = (r_state == LOCKED);
    assign o_sync_err = r_sync_err;

endmodule

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
// Receive end of the 4:1 TDM link. Collects slots 0..2 in a shadow register
// and, on the slot-3 beat, updates all four channels at once.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din          slot data (WIDTH bits)
//   din_valid    qualifies din and frame_sync
//   frame_sync   marks slot 0
//   data_out     channel k at [k*WIDTH +: WIDTH]; holds until the next frame
//   out_valid    one-cycle pulse when data_out updates
//   locked       frame alignment acquired
//   sync_err     one-cycle pulse on a marker at slot != 0 while locked
// -----------------------------------------------------------------------------
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [NUM_SLOTS*WIDTH-1:0] data_out,
    output logic                     out_valid,
    output logic                     locked,
    output logic                     sync_err
);

    logic                       w_wr_en;
    logic [SLOT_W-1:0]          w_wr_slot;
    logic                       w_frame_done;

    // Slot 3 goes straight from din into data_out, so only slots 0..2 are held.
    logic [WIDTH-1:0]           r_shadow [NUM_SLOTS-1];
    logic [NUM_SLOTS*WIDTH-1:0] r_data_out;
    logic                       r_out_valid;

    tdm_frame_tracker #(
        .MISS_LIMIT (MISS_LIMIT)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (din_valid),
        .i_sync       (frame_sync),
        .o_wr_en      (w_wr_en),
        .o_wr_slot    (w_wr_slot),
        .o_frame_done (w_frame_done),
        .o_locked     (locked),
        .o_sync_err   (sync_err)
    );

    // NOTE: the shadow is a handful of flops, not a RAM, so it is reset with
    // everything else; a reset mid-frame leaves no stale partial data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                r_shadow[k] <= '0;
            end
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_frame_done;
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                if (w_wr_en && (w_wr_slot == SLOT_W'(k))) begin
                    r_shadow[k] <= din;
                end
            end
            if (w_frame_done) begin
                r_data_out <= {din, r_shadow[2], r_shadow[1], r_shadow[0]};
            end
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1to4
// Drives a WIDTH=8 and a WIDTH=1 instance with the same beats (the 1-bit
// instance sees bit 0 of each slot) and compares both against a beat-level
// reference model every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1to4;

    localparam int MISS_LIMIT = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        ov;
        logic        serr;
        logic        locked;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din8 = '0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] data8;
    logic [3:0]  data1;
    logic        ov8, ov1, locked8, locked1, serr8, serr1;

    int n_checks = 0;
    int n_errors = 0;
    int n_ov1    = 0;
    bit cmp_en   = 1'b0;

    // Reference model state
    bit         m_locked;
    int         m_pos;
    int         m_miss;
    logic [7:0] m_slots [4];
    exp_t       exp_pend = '0;
    exp_t       exp_cur  = '0;

    always #5 clk = ~clk;

    tdm_demux_1to4 #(.WIDTH(8), .MISS_LIMIT(MISS_LIMIT)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(din_valid),
        .frame_sync(frame_sync), .data_out(data8), .out_valid(ov8),
        .locked(locked8), .sync_err(serr8)
    );

    tdm_demux_1to4 #(.WIDTH(1), .MISS_LIMIT(MISS_LIMIT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din8[0]), .din_valid(din_valid),
        .frame_sync(frame_sync), .data_out(data1), .out_valid(ov1),
        .locked(locked1), .sync_err(serr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_miss   = 0;
        for (int k = 0; k < 4; k++) m_slots[k] = '0;
        exp_pend = '0;
    endtask

    // Expected outputs after the clock edge that consumes this beat.
    task automatic model_step(input bit v, input bit fs, input logic [7:0] d);
        exp_pend.ov   = 1'b0;
        exp_pend.serr = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_slots[0] = d; m_pos = 1; m_locked = 1'b1; m_miss = 0;
                end
            end else if (fs && m_pos != 0) begin
                exp_pend.serr = 1'b1;
                m_slots[0] = d; m_pos = 1; m_miss = 0;
            end else if (m_pos == 0) begin
                m_miss = fs ? 0 : m_miss + 1;
                if (m_miss == MISS_LIMIT) begin
                    m_locked = 1'b0; m_pos = 0; m_miss = 0;
                end else begin
                    m_slots[0] = d; m_pos = 1;
                end
            end else begin
                m_slots[m_pos] = d;
                if (m_pos == 3) begin
                    exp_pend.data = {d, m_slots[2], m_slots[1], m_slots[0]};
                    exp_pend.ov   = 1'b1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        exp_pend.locked = m_locked;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_cur <= '0;
        else        exp_cur <= exp_pend;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("data8",   data8,   exp_cur.data);
            check("data1",   {28'd0, data1},
                  {28'd0, exp_cur.data[24], exp_cur.data[16], exp_cur.data[8], exp_cur.data[0]});
            check("ov8",     {31'd0, ov8},     {31'd0, exp_cur.ov});
            check("ov1",     {31'd0, ov1},     {31'd0, exp_cur.ov});
            check("serr8",   {31'd0, serr8},   {31'd0, exp_cur.serr});
            check("serr1",   {31'd0, serr1},   {31'd0, exp_cur.serr});
            check("locked8", {31'd0, locked8}, {31'd0, exp_cur.locked});
            check("locked1", {31'd0, locked1}, {31'd0, exp_cur.locked});
            if (ov1 === 1'b1) n_ov1++;
        end
    end

    // Drive one beat just after a rising edge; outputs for it appear after the next edge.
    task automatic beat(input bit v, input bit fs, input logic [7:0] d);
        @(posedge clk);
        #1;
        din_valid  = v;
        frame_sync = fs;
        din8       = d;
        model_step(v, fs, d);
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        din_valid = 1'b0; frame_sync = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int tx_slot;
        bit v, fs, quiet;
        logic [3:0] bits;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_data8",  data8, 32'h0);
        check("rst_data1",  {28'd0, data1}, 32'h0);
        check("rst_locked", {30'd0, locked8, locked1}, 32'h0);
        check("rst_ov",     {30'd0, ov8, ov1}, 32'h0);
        check("rst_serr",   {30'd0, serr8, serr1}, 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Basic frame, slot bits 1,0,1,1
        bits = 4'b1101;
        beat(1'b1, 1'b1, {7'($urandom), bits[0]});
        beat(1'b1, 1'b0, {7'($urandom), bits[1]});
        check("t1_locked", {31'd0, locked1}, 32'h1);
        beat(1'b1, 1'b0, {7'($urandom), bits[2]});
        beat(1'b1, 1'b0, {7'($urandom), bits[3]});
        beat(1'b0, 1'b0, 8'h00);
        check("t1_ov",    {31'd0, ov1}, 32'h1);
        check("t1_data1", {28'd0, data1}, 32'hD);
        idle(1);
        check("t1_ov_pulse", {31'd0, ov1}, 32'h0);

        // Same frame with 2-cycle gaps
        c0 = n_ov1;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, (i == 0), {7'($urandom), bits[i]});
            idle(2);
        end
        idle(1);
        check("t2_data1",  {28'd0, data1}, 32'hD);
        check("t2_pulses", n_ov1 - c0, 32'd1);

        // Misaligned marker at slot 2
        beat(1'b1, 1'b1, 8'h2C);
        beat(1'b1, 1'b0, 8'h9C);
        beat(1'b1, 1'b1, 8'h35);
        beat(1'b1, 1'b0, 8'h40);
        check("t3_serr", {31'd0, serr8}, 32'h1);
        check("t3_no_ov", {31'd0, ov8}, 32'h0);
        beat(1'b1, 1'b0, 8'h81);
        beat(1'b1, 1'b0, 8'h6E);
        beat(1'b0, 1'b0, 8'h00);
        check("t3_ov",    {31'd0, ov8}, 32'h1);
        check("t3_data8", data8, 32'h6E814035);
        check("t3_data1", {28'd0, data1}, 32'h5);

        // Three consecutive missing markers drop lock
        beat(1'b1, 1'b0, 8'h11); beat(1'b1, 1'b0, 8'h22);
        beat(1'b1, 1'b0, 8'h33); beat(1'b1, 1'b0, 8'h44);
        beat(1'b1, 1'b0, 8'h01); beat(1'b1, 1'b0, 8'h02);
        beat(1'b1, 1'b0, 8'h03); beat(1'b1, 1'b0, 8'h04);
        beat(1'b1, 1'b0, 8'hEE);
        beat(1'b0, 1'b0, 8'h00);
        check("t4_unlocked", {31'd0, locked8}, 32'h0);
        check("t4_stale",    data8, 32'h04030201);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 8'($urandom));
        idle(2);
        check("t4_still_hunt", {31'd0, locked8}, 32'h0);
        check("t4_stale2",     data8, 32'h04030201);

        // After reset: beats without marker are ignored, then acquire at WIDTH=8
        do_reset();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 8'($urandom));
        idle(1);
        check("t5_hunt", {31'd0, locked8}, 32'h0);
        beat(1'b1, 1'b1, 8'hA1); beat(1'b1, 1'b0, 8'hB2);
        beat(1'b1, 1'b0, 8'hC3); beat(1'b1, 1'b0, 8'hD4);
        beat(1'b0, 1'b0, 8'h00);
        check("t6_data8", data8, 32'hD4C3B2A1);
        check("t6_data1", {28'd0, data1}, 32'h5);

        // Async reset mid-frame
        beat(1'b1, 1'b1, 8'h5A);
        beat(1'b1, 1'b0, 8'h6B);
        @(posedge clk);
        #3;
        din_valid = 1'b0; frame_sync = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t7_data8",  data8, 32'h0);
        check("t7_locked", {30'd0, locked8, locked1}, 32'h0);
        check("t7_pulses", {28'd0, ov8, ov1, serr8, serr1}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(1'b1, 1'b0, 8'hC3);
        beat(1'b1, 1'b0, 8'hD4);
        idle(2);
        check("t7_no_relock", {31'd0, locked8}, 32'h0);

        // Randomized traffic with occasional loss of markers and misaligned markers
        tx_slot = 0;
        for (int i = 0; i < 3000; i++) begin
            quiet = ((i / 250) % 4) == 3;
            v = ($urandom % 10) < 7;
            fs = 1'b0;
            if (v && !quiet) begin
                if (tx_slot == 0) fs = ($urandom % 8) != 0;
                else              fs = ($urandom % 20) == 0;
            end
            beat(v, fs, 8'($urandom));
            if (v) tx_slot = fs ? 1 : (tx_slot + 1) % 4;
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
